// File: rtl/ahb_gcd_pkg.sv
// Shared definitions for the AHB-Lite GCD controller: register offsets,
// control/status bit positions and the sequencer state encoding.
package ahb_gcd_pkg;

  // Byte offsets within the slave window (only HADDR[4:2] is decoded)
  localparam logic [4:0] OFF_A      = 5'h00;
  localparam logic [4:0] OFF_B      = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_RESULT = 5'h10;
  localparam logic [4:0] OFF_CYCLES = 5'h14;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  // Transfer size that is honoured for writes
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/ahb_gcd_ctrl.sv
// AHB-Lite slave that launches the GCD engine, waits for its done level,
// and captures the result plus the number of cycles spent waiting.
module ahb_gcd_ctrl
  import ahb_gcd_pkg::*;
(
  input  logic        clk,
  input  logic        RSTn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        eng_start,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  input  logic [31:0] eng_result,
  input  logic        eng_done,
  output logic        irq
);

  // Address-phase capture
  logic        valid_reg;
  logic [2:0]  addr_reg;
  logic        write_reg;
  logic        word_reg;

  // Software-visible state
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        irq_en_reg;
  logic        done_reg;
  logic [31:0] result_reg;
  logic [31:0] cycles_reg;
  logic        start_reg;
  state_t      state_reg;

  // Data-phase decode
  logic [4:0]  off;
  logic        wr_fire;
  logic        busy;
  logic        start_req;
  logic        w1c_done;

  // Only HADDR[4:2] and HTRANS[1] matter; the rest is intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign eng_a     = a_reg;
  assign eng_b     = b_reg;
  assign eng_start = start_reg;
  assign irq       = done_reg & irq_en_reg;

  assign off       = {addr_reg, 2'b00};
  assign busy      = (state_reg != ST_IDLE);
  assign wr_fire   = valid_reg & write_reg & word_reg;
  assign start_req = wr_fire && (off == OFF_CTRL) && HWDATA[CTRL_START] && !busy;
  assign w1c_done  = wr_fire && (off == OFF_STATUS) && HWDATA[STAT_DONE];

  // Register the address phase of every accepted transfer
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      valid_reg <= 1'b0;
      addr_reg  <= 3'd0;
      write_reg <= 1'b0;
      word_reg  <= 1'b0;
    end else begin
      valid_reg <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        addr_reg  <= HADDR[4:2];
        write_reg <= HWRITE;
        word_reg  <= (HSIZE == HSIZE_WORD);
      end
    end
  end

  // Operand and interrupt-enable writes; operands are frozen while busy
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      irq_en_reg <= 1'b0;
    end else if (wr_fire) begin
      if (off == OFF_A && !busy) a_reg <= HWDATA;
      if (off == OFF_B && !busy) b_reg <= HWDATA;
      if (off == OFF_CTRL)       irq_en_reg <= HWDATA[CTRL_IRQ_EN];
    end
  end

  // Sequencer: issue start, count wait cycles, capture result and done
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg  <= ST_IDLE;
      start_reg  <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= 32'd0;
      cycles_reg <= 32'd0;
    end else begin
      // W1C first so that a capture in the same edge overrides it
      if (w1c_done) done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          start_reg <= 1'b0;
          if (start_req) begin
            state_reg  <= ST_ISSUE;
            start_reg  <= 1'b1;
            done_reg   <= 1'b0;
            cycles_reg <= 32'd0;
          end
        end
        ST_ISSUE: begin
          start_reg <= 1'b0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          start_reg <= 1'b0;
          if (eng_done) begin
            result_reg <= eng_result;
            done_reg   <= 1'b1;
            state_reg  <= ST_IDLE;
          end else if (cycles_reg != 32'hFFFF_FFFF) begin
            cycles_reg <= cycles_reg + 32'd1;
          end
        end
        default: begin
          start_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux driven from the registered address during the data phase
  always_comb begin
    HRDATA = 32'd0;
    if (valid_reg && !write_reg) begin
      case (off)
        OFF_A:      HRDATA = a_reg;
        OFF_B:      HRDATA = b_reg;
        OFF_CTRL:   HRDATA = {30'd0, irq_en_reg, 1'b0};
        OFF_STATUS: HRDATA = {30'd0, done_reg, busy};
        OFF_RESULT: HRDATA = result_reg;
        OFF_CYCLES: HRDATA = cycles_reg;
        default:    HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_gcd_ctrl.sv
// Directed bench for ahb_gcd_ctrl with a behavioural Euclid engine beside it.
// The engine output can be overridden to place done edges exactly.
module tb_ahb_gcd_ctrl;

  logic        clk;
  logic        RSTn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        eng_start;
  logic [31:0] eng_a;
  logic [31:0] eng_b;
  logic [31:0] eng_result;
  logic        eng_done;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  // Engine model state and manual override
  logic [31:0] mx, my, mres;
  logic        mrun, mdone;
  logic        manual;
  logic        man_done;
  logic [31:0] man_result;

  assign eng_done   = manual ? man_done   : mdone;
  assign eng_result = manual ? man_result : mres;

  ahb_gcd_ctrl dut (
    .clk(clk), .RSTn(RSTn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_result(eng_result), .eng_done(eng_done), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Euclid engine: one remainder step per cycle, done level held until next start
  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      mx <= 0; my <= 0; mres <= 0; mrun <= 0; mdone <= 0;
    end else if (eng_start) begin
      mx <= eng_a; my <= eng_b; mrun <= 1'b1; mdone <= 1'b0;
    end else if (mrun) begin
      if (my == 0) begin
        mrun <= 1'b0; mdone <= 1'b1; mres <= mx;
      end else begin
        mx <= my; my <= mx % my;
      end
    end
  end

  // Count cycles with eng_start high
  always @(posedge clk) begin
    if (eng_start === 1'b1) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Both tasks start and end 1 time unit after a rising edge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] size = 3'b010);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = addr; HSIZE = size;
    @(posedge clk); #1;
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = data;
    @(posedge clk); #1;
    $display("write addr=%h data=%h size=%0d", addr, data, size);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = addr; HSIZE = 3'b010;
    @(posedge clk); #1;
    HSEL = 0; HTRANS = 2'b00;
    data = HRDATA;
    @(posedge clk); #1;
    $display("read  addr=%h data=%h", addr, data);
  endtask

  task automatic poll_done(input string tag);
    logic [31:0] st;
    st = 32'hDEAD;
    for (int i = 0; i < 60; i++) begin
      bus_read(32'h0C, st);
      if (st == 32'h2) break;
    end
    chk(tag, st, 32'h2);
  endtask

  initial begin
    logic [31:0] rd;
    int          cnt0;

    RSTn = 0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 3'b010;
    HWDATA = 0; HREADY = 1; manual = 0; man_done = 0; man_result = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_start", {31'd0, eng_start}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    RSTn = 1;
    @(posedge clk); #1;
    bus_read(32'h0C, rd); chk("rst_status", rd, 32'h0);
    chk("rst_eng_a", eng_a, 32'h0);

    // GCD(48,18) with interrupt enabled
    bus_write(32'h00, 48);
    bus_write(32'h04, 18);
    bus_write(32'h08, 32'h3);
    bus_read(32'h0C, rd); chk("t1_busy", rd, 32'h1);
    poll_done("t1_poll");
    bus_read(32'h10, rd); chk("t1_result", rd, 32'd6);
    bus_read(32'h14, rd); chk("t1_cycles", rd, 32'd4);
    chk("t1_irq", {31'd0, irq}, 32'h1);
    bus_write(32'h0C, 32'h2);
    bus_read(32'h0C, rd); chk("t1_w1c", rd, 32'h0);
    chk("t1_irq_clr", {31'd0, irq}, 32'h0);

    // GCD(7,0): one wait cycle, one start pulse
    cnt0 = start_cnt;
    bus_write(32'h00, 7);
    bus_write(32'h04, 0);
    bus_write(32'h08, 32'h3);
    poll_done("t2_poll");
    bus_read(32'h10, rd); chk("t2_result", rd, 32'd7);
    bus_read(32'h14, rd); chk("t2_cycles", rd, 32'd1);
    chk("t2_pulses", start_cnt - cnt0, 32'd1);
    bus_read(32'h08, rd); chk("t2_ctrl", rd, 32'h2);

    // Writes while busy are ignored; engine held off manually
    manual = 1; man_done = 0;
    cnt0 = start_cnt;
    bus_write(32'h08, 32'h3);
    bus_write(32'h00, 100);
    bus_read(32'h00, rd); chk("t3_a_frozen", rd, 32'd7);
    bus_write(32'h08, 32'h3);
    bus_read(32'h0C, rd); chk("t3_busy", rd, 32'h1);
    chk("t3_pulses", start_cnt - cnt0, 32'd1);

    // W1C of done lands on the capture edge: completion wins
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0C; HSIZE = 3'b010;
    @(posedge clk); #1;
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = 32'h2;
    man_done = 1; man_result = 32'h55;
    @(posedge clk); #1;
    man_done = 0;
    $display("write addr=0000000c data=00000002 with capture");
    bus_read(32'h0C, rd); chk("t4_done_wins", rd, 32'h2);
    bus_read(32'h10, rd); chk("t4_result", rd, 32'h55);
    chk("t4_irq", {31'd0, irq}, 32'h1);

    // Reset during WAIT clears everything
    bus_write(32'h08, 32'h3);
    bus_read(32'h0C, rd); chk("t5_busy", rd, 32'h1);
    RSTn = 0;
    repeat (2) @(posedge clk);
    #1;
    RSTn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bus_read(32'(i * 4), rd);
      chk($sformatf("t5_rst_reg%0d", i), rd, 32'h0);
    end
    chk("t5_irq", {31'd0, irq}, 32'h0);
    manual = 0;
    bus_write(32'h00, 12);
    bus_write(32'h04, 8);
    bus_write(32'h08, 32'h1);
    poll_done("t5_poll");
    bus_read(32'h10, rd); chk("t5_result", rd, 32'd4);
    chk("t5_irq_off", {31'd0, irq}, 32'h0);

    // Byte write ignored, unmapped read returns 0, bus response constant
    bus_write(32'h00, 99, 3'b000);
    bus_read(32'h00, rd); chk("t6_byte_ign", rd, 32'd12);
    bus_read(32'h18, rd); chk("t6_unmapped", rd, 32'h0);
    chk("t6_hreadyout", {31'd0, HREADYOUT}, 32'h1);
    chk("t6_hresp", {31'd0, HRESP}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
